// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection and writeback bypass.
//
// Purpose:
//   Registers the decoded instruction from IF/ID into the EX stage. A load in EX whose
//   destination is read by the instruction in IF/ID raises stall and loads one bubble.
//   A flush (redirect resolved in EX) loads a bubble and overrides the stall. Register-file
//   operands are bypassed from the same-cycle writeback when the specifiers match.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   ifid_*                     decoded instruction fields from IF/ID
//   MEMWB_RegWrite/Rd/data     writeback port active in the same cycle
//   flush                      redirect resolved in EX; forces a bubble
//   IDEX_* / ReadingR*_IDEX    registered controls and specifiers
//   nakedA, nakedB             registered operands (after writeback bypass)
//   stall                      combinational; freezes PC and IF/ID
//   bubble_cnt                 bubble counter
//
// Configuration:
//   IDEX_BUBBLE_CNT_EN  when defined, bubble_cnt counts bubbles loaded while IF/ID held a
//                       valid instruction (saturating). Otherwise bubble_cnt is tied to 0.

module idex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifid_valid,
  input  logic [REG_W-1:0]  ifid_Rs,
  input  logic [REG_W-1:0]  ifid_Rt,
  input  logic [REG_W-1:0]  ifid_Rd,
  input  logic              ifid_ReadingRs,
  input  logic              ifid_ReadingRt,
  input  logic              ifid_RegWrite,
  input  logic              ifid_MemRead,
  input  logic              ifid_MemWrite,
  input  logic [DATA_W-1:0] ifid_A,
  input  logic [DATA_W-1:0] ifid_B,
  input  logic [DATA_W-1:0] ifid_Imm,
  input  logic [DATA_W-1:0] ifid_PC,
  input  logic              MEMWB_RegWrite,
  input  logic [REG_W-1:0]  MEMWB_Rd,
  input  logic [DATA_W-1:0] MEMWB_data,
  input  logic              flush,
  output logic              IDEX_valid,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemRead,
  output logic              IDEX_MemWrite,
  output logic              ReadingRs_IDEX,
  output logic              ReadingRt_IDEX,
  output logic [REG_W-1:0]  IDEX_Rs,
  output logic [REG_W-1:0]  IDEX_Rt,
  output logic [REG_W-1:0]  IDEX_Rd,
  output logic [DATA_W-1:0] nakedA,
  output logic [DATA_W-1:0] nakedB,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic [DATA_W-1:0] IDEX_PC,
  output logic              stall,
  output logic [15:0]       bubble_cnt
);

  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_reading_rs;
  logic              r_reading_rt;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc;

  logic              w_load_use;
  logic              w_capture;
  logic              w_bubble;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  // A load in EX that writes a register the IF/ID instruction actually reads.
  always_comb begin
    w_load_use = r_valid && r_mem_read && r_reg_write && ifid_valid &&
                 ((ifid_ReadingRs && (ifid_Rs == r_rd)) ||
                  (ifid_ReadingRt && (ifid_Rt == r_rd)));
  end

  // Flush wins: the stalled instruction is on the wrong path anyway.
  assign stall     = w_load_use && !flush;
  assign w_capture = !flush && !w_load_use && ifid_valid;
  assign w_bubble  = !w_capture;

  // Register file is written in the same cycle it is read, so pick up that write here.
  always_comb begin
    w_a = ifid_A;
    w_b = ifid_B;
    if (MEMWB_RegWrite && (MEMWB_Rd == ifid_Rs)) w_a = MEMWB_data;
    if (MEMWB_RegWrite && (MEMWB_Rd == ifid_Rt)) w_b = MEMWB_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reading_rs <= 1'b0;
      r_reading_rt <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
    end else if (w_capture) begin
      r_valid      <= 1'b1;
      r_reg_write  <= ifid_RegWrite;
      r_mem_read   <= ifid_MemRead;
      r_mem_write  <= ifid_MemWrite;
      r_reading_rs <= ifid_ReadingRs;
      r_reading_rt <= ifid_ReadingRt;
      r_rs         <= ifid_Rs;
      r_rt         <= ifid_Rt;
      r_rd         <= ifid_Rd;
      r_a          <= w_a;
      r_b          <= w_b;
      r_imm        <= ifid_Imm;
      r_pc         <= ifid_PC;
    end else begin
      // Bubble: kill controls only; data fields keep their old contents.
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reading_rs <= 1'b0;
      r_reading_rt <= 1'b0;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;

  // Counts only bubbles that displaced a real instruction (stall or flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= 16'h0000;
    end else if (ifid_valid && w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`else
  assign bubble_cnt = 16'h0000;
`endif

  assign IDEX_valid     = r_valid;
  assign IDEX_RegWrite  = r_reg_write;
  assign IDEX_MemRead   = r_mem_read;
  assign IDEX_MemWrite  = r_mem_write;
  assign ReadingRs_IDEX = r_reading_rs;
  assign ReadingRt_IDEX = r_reading_rt;
  assign IDEX_Rs        = r_rs;
  assign IDEX_Rt        = r_rt;
  assign IDEX_Rd        = r_rd;
  assign nakedA         = r_a;
  assign nakedB         = r_b;
  assign IDEX_Imm       = r_imm;
  assign IDEX_PC        = r_pc;

endmodule
